// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-to-serial front end. Accepts WIDTH-bit words over a
//            valid/ready handshake and emits them one bit per clock on sout.
//            A one-word holding buffer lets consecutive words stream with no
//            idle cycle; stall freezes the shifter without losing data.
// Ports    : clk        - clock, all state on rising edge
//            rstn       - asynchronous active-low reset
//            din        - word to serialize
//            din_valid  - din holds a word
//            din_ready  - block can take a word (registered)
//            stall      - freeze shifter
//            sout       - current serial bit, 0 when sout_valid=0
//            sout_valid - sout carries a data bit
//            last       - sout is the final bit of its word
//            words_sent - count of fully emitted words (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             stall,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic [15:0]      words_sent
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [15:0]        words_sent_q, words_sent_d;

    logic               out_bit;
    logic [WIDTH-1:0]   sreg_shifted;
    logic               active;
    logic               accept;
    logic               adv;
    logic               done;
    logic               free;

    // Bit order only changes which end of the shifter faces sout.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign out_bit      = sreg_q[WIDTH-1];
            assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign out_bit      = sreg_q[0];
            assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign active = (state_q == SHIFT);
    // Ready depends only on the buffer flop, so no path from din_valid/stall.
    assign accept = din_valid && !hold_full_q;
    assign adv    = active && !stall;
    assign done   = adv && (cnt_q == CNT_LAST);
    // Shifter can take a new word this edge: idle, or retiring its last bit.
    assign free   = !active || done;

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        words_sent_d = words_sent_q;

        if (done) begin
            words_sent_d = words_sent_q + 16'd1;
        end

        if (free) begin
            // Buffered word has priority; accept cannot coincide with a
            // full buffer because din_ready is low then.
            if (hold_full_q) begin
                sreg_d      = hold_q;
                hold_full_d = 1'b0;
                cnt_d       = '0;
                state_d     = SHIFT;
            end else if (accept) begin
                sreg_d  = din;
                cnt_d   = '0;
                state_d = SHIFT;
            end else begin
                state_d = IDLE;
            end
        end else begin
            if (accept) begin
                hold_d      = din;
                hold_full_d = 1'b1;
            end
            if (adv) begin
                sreg_d = sreg_shifted;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign sout       = active && out_bit;
    assign sout_valid = active;
    assign last       = active && (cnt_q == CNT_LAST);
    assign din_ready  = !hold_full_q;
    assign words_sent = words_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Directed self-checking bench for bit_serializer. One LSB-first
//            instance and one MSB-first instance share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    logic        clk;
    logic        rstn;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        stall;
    logic        sout;
    logic        sout_valid;
    logic        last;
    logic [15:0] words_sent;

    logic [7:0]  din_m;
    logic        din_valid_m;
    logic        din_ready_m;
    logic        stall_m;
    logic        sout_m;
    logic        sout_valid_m;
    logic        last_m;
    logic [15:0] words_sent_m;

    int checks;
    int failures;
    logic [15:0] exp_ws;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .stall      (stall),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last),
        .words_sent (words_sent)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din_m),
        .din_valid  (din_valid_m),
        .din_ready  (din_ready_m),
        .stall      (stall_m),
        .sout       (sout_m),
        .sout_valid (sout_valid_m),
        .last       (last_m),
        .words_sent (words_sent_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({sout, sout_valid, last, din_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_outputs: got sout/valid/last/ready=%b required 0001",
                     {sout, sout_valid, last, din_ready});
        end
        checks++;
        if (words_sent !== 16'h0000) begin
            failures++;
            $display("FAIL reset_words_sent: got %h required 0000", words_sent);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Single A5 word, LSB first, bits on cycles 1..8.
    task automatic test_lsb_word();
        int exp_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        din = 8'hA5;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if (sout_valid !== (c <= 8)) begin
                failures++;
                $display("FAIL lsb_valid c%0d: got %b required %b", c, sout_valid, (c <= 8));
            end
            checks++;
            if (last !== (c == 8)) begin
                failures++;
                $display("FAIL lsb_last c%0d: got %b required %b", c, last, (c == 8));
            end
            if (c <= 8) begin
                checks++;
                if (sout !== exp_bits[c-1][0]) begin
                    failures++;
                    $display("FAIL lsb_bit c%0d: got %b required %0d", c, sout, exp_bits[c-1]);
                end
            end else begin
                exp_ws = exp_ws + 16'd1;
                checks++;
                if (sout !== 1'b0 || words_sent !== exp_ws) begin
                    failures++;
                    $display("FAIL lsb_end: got sout=%b ws=%h required sout=0 ws=%h",
                             sout, words_sent, exp_ws);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // 55 then AA with valid held: 16 contiguous bits, ready low cycles 2-8.
    task automatic test_back_to_back();
        int exp_bits[16] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1};
        din = 8'h55;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din = 8'hAA;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            checks++;
            if (sout_valid !== (c <= 16)) begin
                failures++;
                $display("FAIL b2b_valid c%0d: got %b required %b", c, sout_valid, (c <= 16));
            end
            checks++;
            if (last !== (c == 8 || c == 16)) begin
                failures++;
                $display("FAIL b2b_last c%0d: got %b required %b", c, last, (c == 8 || c == 16));
            end
            checks++;
            if (din_ready !== !(c >= 2 && c <= 8)) begin
                failures++;
                $display("FAIL b2b_ready c%0d: got %b required %b", c, din_ready, !(c >= 2 && c <= 8));
            end
            if (c <= 16) begin
                checks++;
                if (sout !== exp_bits[c-1][0]) begin
                    failures++;
                    $display("FAIL b2b_bit c%0d: got %b required %0d", c, sout, exp_bits[c-1]);
                end
            end
            if (c == 9 || c == 17) begin
                exp_ws = exp_ws + 16'd1;
                checks++;
                if (words_sent !== exp_ws) begin
                    failures++;
                    $display("FAIL b2b_words c%0d: got %h required %h", c, words_sent, exp_ws);
                end
            end
            @(posedge clk);
            #1;
            if (c == 1) din_valid = 1'b0;
        end
    endtask

    // A5 with stall high during cycles 3-5: bit 3 held for 4 cycles.
    task automatic test_stall();
        int exp_bits[11] = '{1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1};
        din = 8'hA5;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (sout_valid !== (c <= 11)) begin
                failures++;
                $display("FAIL stall_valid c%0d: got %b required %b", c, sout_valid, (c <= 11));
            end
            checks++;
            if (last !== (c == 11)) begin
                failures++;
                $display("FAIL stall_last c%0d: got %b required %b", c, last, (c == 11));
            end
            if (c <= 11) begin
                checks++;
                if (sout !== exp_bits[c-1][0]) begin
                    failures++;
                    $display("FAIL stall_bit c%0d: got %b required %0d", c, sout, exp_bits[c-1]);
                end
            end else begin
                exp_ws = exp_ws + 16'd1;
                checks++;
                if (words_sent !== exp_ws) begin
                    failures++;
                    $display("FAIL stall_words: got %h required %h", words_sent, exp_ws);
                end
            end
            @(posedge clk);
            #1 stall = (c + 1 >= 3 && c + 1 <= 5);
        end
        stall = 1'b0;
    endtask

    // Reset during bit 4 with a word waiting in the buffer.
    task automatic test_reset_midword();
        din = 8'hA5;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din = 8'h3C;
        @(posedge clk);
        #1 din_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (din_ready !== 1'b0 || sout_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: got ready=%b valid=%b required ready=0 valid=1",
                     din_ready, sout_valid);
        end
        rstn = 1'b0;
        #1;
        exp_ws = 16'h0000;
        checks++;
        if ({sout, sout_valid, last, din_ready} !== 4'b0001 || words_sent !== exp_ws) begin
            failures++;
            $display("FAIL rst_async: got sout/valid/last/ready=%b ws=%h required 0001 ws=0000",
                     {sout, sout_valid, last, din_ready}, words_sent);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (sout_valid !== 1'b0 || sout !== 1'b0 || din_ready !== 1'b1 || words_sent !== 16'h0) begin
                failures++;
                $display("FAIL rst_after c%0d: got valid=%b sout=%b ready=%b ws=%h required 0 0 1 0000",
                         c, sout_valid, sout, din_ready, words_sent);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_msb_first();
        int exp_bits[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        din_m = 8'h80;
        din_valid_m = 1'b1;
        @(posedge clk);
        #1 din_valid_m = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if (sout_valid_m !== (c <= 8) || last_m !== (c == 8)) begin
                failures++;
                $display("FAIL msb_ctrl c%0d: got valid=%b last=%b required %b %b",
                         c, sout_valid_m, last_m, (c <= 8), (c == 8));
            end
            if (c <= 8) begin
                checks++;
                if (sout_m !== exp_bits[c-1][0]) begin
                    failures++;
                    $display("FAIL msb_bit c%0d: got %b required %0d", c, sout_m, exp_bits[c-1]);
                end
            end else begin
                checks++;
                if (words_sent_m !== 16'h0001) begin
                    failures++;
                    $display("FAIL msb_words: got %h required 0001", words_sent_m);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Counter preloaded near the top; two words cross the wrap point.
    task automatic test_wrap();
        logic [15:0] exp_after[2] = '{16'hFFFF, 16'h0000};
        @(negedge clk);
        force dut.words_sent_q = 16'hFFFE;
        #1 release dut.words_sent_q;
        @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            din = 8'h0F;
            din_valid = 1'b1;
            @(posedge clk);
            #1 din_valid = 1'b0;
            repeat (8) @(posedge clk);
            @(negedge clk);
            checks++;
            if (words_sent !== exp_after[w]) begin
                failures++;
                $display("FAIL wrap_word%0d: got %h required %h", w, words_sent, exp_after[w]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_ws      = 16'h0000;
        rstn        = 1'b0;
        din         = 8'h00;
        din_valid   = 1'b0;
        stall       = 1'b0;
        din_m       = 8'h00;
        din_valid_m = 1'b0;
        stall_m     = 1'b0;

        test_reset();
        test_lsb_word();
        test_back_to_back();
        test_stall();
        test_reset_midword();
        test_msb_first();
        test_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
